// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch datapath: state encoding and counter width helper.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;
    localparam logic [1:0] ST_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE    = ST_IDLE,
        S_RUNNING = ST_RUNNING,
        S_PAUSED  = ST_PAUSED,
        S_ILLEGAL = ST_ILLEGAL
    } state_t;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned TICKS_W_DEFAULT = cnt_width(100_000_000);

endpackage

// File: rtl/sw_button_cond.sv
// One button: 2-flop synchronizer, optional debounce (STOPWATCH_DEBOUNCE_EN), registered
// rising-edge detect giving a single-cycle press pulse.
module sw_button_cond
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_press
);

    logic [1:0] r_sync;
    logic       r_prev;
    logic       r_press;
    logic       w_level;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_level;

    // Accepted level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (r_sync[1] == r_db_level) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
            r_db_cnt   <= '0;
            r_db_level <= r_sync[1];
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    assign w_level = r_db_level;
`else
    assign w_level = r_sync[1];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_prev  <= w_level;
            r_press <= w_level & ~r_prev;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control: button conditioning, idle/run/pause FSM, seconds prescaler, clear pulse.
// Optional button debounce is enabled by defining STOPWATCH_DEBOUNCE_EN.
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC   = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start_btn,
    input  logic       i_stop_btn,
    input  logic       i_clear_btn,
    output logic       o_tick,
    output logic       o_running,
    output logic       o_paused,
    output logic       o_clear,
    output logic [1:0] o_state
);

    localparam int unsigned PRESC_W = cnt_width(TICKS_PER_SEC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    logic w_start_p;
    logic w_stop_p;
    logic w_clear_p;

    sw_button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_start_btn),
        .o_press (w_start_p)
    );

    sw_button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_stop_btn),
        .o_press (w_stop_p)
    );

    sw_button_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_btn   (i_clear_btn),
        .o_press (w_clear_p)
    );

    state_t               r_state;
    state_t               w_state_d;
    logic [PRESC_W-1:0]   r_presc;
    logic [PRESC_W-1:0]   w_presc_d;
    logic                 r_tick;
    logic                 w_tick_d;
    logic                 r_clear;
    logic                 w_clear_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_clear <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_presc <= w_presc_d;
            r_tick  <= w_tick_d;
            r_clear <= w_clear_d;
        end
    end

    // Clear beats stop beats start; a departing cycle never ticks.
    always_comb begin
        w_state_d = r_state;
        w_presc_d = r_presc;
        w_tick_d  = 1'b0;
        w_clear_d = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_presc_d = '0;
                if (w_clear_p) begin
                    w_clear_d = 1'b1;
                end else if (w_start_p) begin
                    w_state_d = S_RUNNING;
                end
            end
            S_RUNNING: begin
                if (w_clear_p) begin
                    w_state_d = S_IDLE;
                    w_presc_d = '0;
                    w_clear_d = 1'b1;
                end else if (w_stop_p) begin
                    w_state_d = S_PAUSED;
                end else if (r_presc == PRESC_LAST) begin
                    w_presc_d = '0;
                    w_tick_d  = 1'b1;
                end else begin
                    w_presc_d = r_presc + 1'b1;
                end
            end
            S_PAUSED: begin
                if (w_clear_p) begin
                    w_state_d = S_IDLE;
                    w_presc_d = '0;
                    w_clear_d = 1'b1;
                end else if (w_start_p) begin
                    w_state_d = S_RUNNING;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_presc_d = '0;
            end
        endcase
    end

    assign o_tick    = r_tick;
    assign o_clear   = r_clear;
    assign o_state   = r_state;
    assign o_running = (r_state == S_RUNNING);
    assign o_paused  = (r_state == S_PAUSED);

endmodule

// File: doc/stopwatch_control.md
# stopwatch_control

Upstream control stage of the stopwatch datapath. It turns raw start/stop/clear button inputs into a run/pause/idle state, and generates the one-cycle-per-second `tick` that drives the seconds counter's `enable`. It also issues a synchronous `clear` pulse so the downstream counters can be zeroed without asserting reset.

## Interface
- `TICKS_PER_SEC`, default 100_000_000: `clk` cycles per `tick`. Must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: stable-high cycles needed to accept a press. Used only when `STOPWATCH_DEBOUNCE_EN` is defined.
- `clk`  input  1  system clock; all logic is rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start_btn`  input  1  raw start button (asynchronous, level).
- `stop_btn`  input  1  raw stop/pause button.
- `clear_btn`  input  1  raw clear button.
- `tick`  output  1  one-cycle pulse, once per second while running; connects to the seconds counter's `enable`.
- `running`  output  1  high in RUNNING.
- `paused`  output  1  high in PAUSED.
- `clear`  output  1  one-cycle synchronous clear pulse to the counters.
- `state`  output  2  current FSM state encoding.

## Operation
- Input path, per button:
  - 2-flop synchronizer, then rising-edge detect, giving a one-cycle press pulse (`start_p`, `stop_p`, `clear_p`).
  - A held button produces exactly one pulse.
- FSM states: IDLE = 2'b00, RUNNING = 2'b01, PAUSED = 2'b10. 2'b11 is illegal and recovers to IDLE on the next edge.
- Priority when pulses coincide: clear > stop > start.
- Transitions:
  - IDLE: `start_p` → RUNNING. `stop_p` is ignored. `clear_p` stays IDLE and emits `clear`.
  - RUNNING: `stop_p` → PAUSED. `clear_p` → IDLE and emits `clear`. `start_p` is ignored.
  - PAUSED: `start_p` → RUNNING. `clear_p` → IDLE and emits `clear`. `stop_p` is ignored.
- Prescaler, width `$clog2(TICKS_PER_SEC)`:
  - RUNNING: increments each cycle. At value `TICKS_PER_SEC-1` it wraps to 0 and `tick` is registered high for the next cycle.
  - PAUSED: holds its value, so the partial second is preserved across a pause.
  - IDLE: forced to 0.
- Departure cycle: in any cycle where `stop_p` or `clear_p` is acted on, no `tick` is generated. The prescaler holds on stop and zeroes on clear.
- `clear` is generated in every state on `clear_p`, including IDLE.
- `running`, `paused` and `state` are decoded from the state register (glitch-free, no extra latency).

## Timing
- Reset values: `state` = IDLE, `tick` = 0, `running` = 0, `paused` = 0, `clear` = 0. The prescaler and all synchronizer/edge flops are also 0.
- Reset mid-count: the prescaler and FSM return to 0/IDLE immediately (asynchronous); no `tick` or `clear` is emitted on reset deassertion.
- Button latency: if `btn` is first sampled high at edge N, the state register updates at edge N+3. `clear` is high for the cycle following that edge N+3.
- First `tick` after entering RUNNING from IDLE is high `TICKS_PER_SEC` cycles after `running` rises. Subsequent ticks follow at exactly `TICKS_PER_SEC`-cycle spacing.
- Resume from PAUSED: first `tick` arrives after the remaining `TICKS_PER_SEC - held` cycles.
- `tick` is never high for two consecutive cycles.

## Configuration
- `STOPWATCH_DEBOUNCE_EN` defined:
  - Each synchronized button must be stable high for `DEBOUNCE_CYCLES` consecutive cycles before its press pulse fires.
  - Each button must read low for `DEBOUNCE_CYCLES` cycles before it can re-arm.
  - Button latency becomes N+3+`DEBOUNCE_CYCLES`.
- Not defined: no filter and no debounce counters are instantiated; latency is as in Timing.

## Structure
- `stopwatch_pkg`: state encoding localparams (`ST_IDLE`, `ST_RUNNING`, `ST_PAUSED`) and a `clog2`-based width helper constant. The seconds and minutes counters share this package.
- Sub-module `sw_button_cond`: synchronizer, optional debounce and edge detect for one button. It is instantiated three times; the debounce logic sits inside it, under the macro.
- Top level holds only the FSM, the prescaler and the output registers.

## Test plan
Bench uses `TICKS_PER_SEC` = 10, `DEBOUNCE_CYCLES` = 4; debounce scenarios are run with the macro both on and off.
- Reset, then pulse `start_btn` → `running` = 1 at edge N+3; `tick` pulses at 10, 20 and 30 cycles after `running` rises, each one cycle wide.
- Run 13 cycles, press stop, wait 50 cycles, press start → no `tick` while paused; the next `tick` comes 7 cycles after resume.
- Press clear while RUNNING → one-cycle `clear` pulse, `state` = 00, prescaler = 0; the next start gives the first `tick` after 10 cycles.
- Assert start, stop and clear in the same cycle from RUNNING → clear wins: IDLE, `clear` pulse, no `tick`.
- Hold `start_btn` for 100 cycles in IDLE, and (macro on) drive 3-cycle glitches → exactly one press accepted, glitches ignored.
- Assert `rst` on the cycle the prescaler = 9 → no `tick`, all outputs 0 immediately.
